// File: rtl/vga_sprite_line_reader_if.sv
// Sprite RAM read port (port 2) as seen from the VGA-side line reader.
interface vga_sprite_line_reader_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [15:0]       mem_readdata;

  modport master (
    output mem_address,
    output mem_chipselect,
    output mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_chipselect,
    input  mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/vga_sprite_line_reader.sv
// Prefetches the next scanline's sprite row into a ping-pong buffer; pixel out 1 cycle after draw_x.
// Fill takes SPR_W+1 cycles, no backpressure; SPRITE_READER_HFLIP_EN adds a mirrored-fetch hflip input.
module vga_sprite_line_reader #(
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int          ADDR_W      = 11
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             line_start,
  input  logic [9:0]                       next_y,
  input  logic [9:0]                       sprite_x,
  input  logic [9:0]                       sprite_y,
  input  logic                             frame_sel,
`ifdef SPRITE_READER_HFLIP_EN
  input  logic                             hflip,
`endif
  input  logic [9:0]                       draw_x,
  vga_sprite_line_reader_if.master         mem,
  output logic [15:0]                      pixel_rgb,
  output logic                             pixel_valid,
  output logic                             fetch_busy,
  output logic                             overrun
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q;
  logic            frame_q;
  logic            bank_sel_q;
  logic [1:0]      valid_q;
  logic [9:0]      x_q [2];
  logic            overrun_q;
  logic            wr_pend_q;
  logic [CW-1:0]   wr_col_q;
  logic            wr_bank_q;
  logic [15:0]     pixel_rgb_q;
  logic            pixel_valid_q;
  logic [15:0]     line_q [2][SPR_W];

  logic [10:0]     row_full;
  logic            row_hit;
  logic            busy;
  logic            issue;
  logic [CW-1:0]   col_issue;
  logic [10:0]     dx;
  logic            dx_hit;
  logic [15:0]     front_word;

  // 11-bit difference keeps a sprite_y above next_y negative instead of wrapping into range
  assign row_full = {1'b0, next_y} - {1'b0, sprite_y};
  assign row_hit  = enable && !row_full[10] && (row_full < 11'(SPR_H));

`ifdef SPRITE_READER_HFLIP_EN
  logic hflip_q;
  assign col_issue = hflip_q ? ~col_q : col_q;
`else
  assign col_issue = col_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a line_start always restarts regardless of the current state
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      FETCH: begin
        col_d = col_q + 1'b1;
        if (col_q == CW'(SPR_W - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      state_d = row_hit ? FETCH : IDLE;
      col_d   = '0;
    end
  end

  // Output logic
  always_comb begin
    busy               = (state_q != IDLE);
    issue              = (state_q == FETCH);
    mem.mem_address    = issue ? ADDR_W'({frame_q, row_q, col_issue}) : '0;
    mem.mem_chipselect = busy;
    mem.mem_clken      = busy;
  end

  assign dx         = {1'b0, draw_x} - {1'b0, x_q[bank_sel_q]};
  assign dx_hit     = valid_q[bank_sel_q] && !dx[10] && (dx < 11'(SPR_W));
  assign front_word = line_q[bank_sel_q][dx[CW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_q       <= 1'b0;
      bank_sel_q    <= 1'b0;
      valid_q       <= '0;
      x_q           <= '{default: '0};
      overrun_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_col_q      <= '0;
      wr_bank_q     <= 1'b0;
      pixel_rgb_q   <= '0;
      pixel_valid_q <= 1'b0;
`ifdef SPRITE_READER_HFLIP_EN
      hflip_q       <= 1'b0;
`endif
    end else begin
      col_q     <= col_d;
      // Write target is frozen at issue time so a swap cannot redirect the in-flight word
      wr_pend_q <= issue;
      wr_col_q  <= col_q;
      wr_bank_q <= ~bank_sel_q;
      if (line_start) begin
        bank_sel_q          <= ~bank_sel_q;
        valid_q[bank_sel_q] <= 1'b0;
        x_q[bank_sel_q]     <= sprite_x;
        row_q               <= row_full[RW-1:0];
        frame_q             <= frame_sel;
`ifdef SPRITE_READER_HFLIP_EN
        hflip_q             <= hflip;
`endif
        if (busy) overrun_q <= 1'b1;
      end else if (state_q == DRAIN) begin
        valid_q[~bank_sel_q] <= 1'b1;
      end
      pixel_rgb_q   <= dx_hit ? front_word : 16'h0000;
      pixel_valid_q <= dx_hit && (front_word != TRANSPARENT);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pend_q) line_q[wr_bank_q][wr_col_q] <= mem.mem_readdata;
  end

  assign pixel_rgb   = pixel_rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign fetch_busy  = busy;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_vga_sprite_line_reader.sv
// Scoreboarded bench for vga_sprite_line_reader with a word=address sprite RAM model.
module tb_vga_sprite_line_reader;
  logic        clk = 1'b0;
  logic        reset, enable, line_start, frame_sel;
  logic [9:0]  next_y, sprite_x, sprite_y, draw_x;
  logic [15:0] pixel_rgb;
  logic        pixel_valid, fetch_busy, overrun;
`ifdef SPRITE_READER_HFLIP_EN
  logic        hflip;
`endif

  always #5 clk = ~clk;

  vga_sprite_line_reader_if #(.ADDR_W(11)) mem_if ();

  vga_sprite_line_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .line_start (line_start),
    .next_y     (next_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .frame_sel  (frame_sel),
`ifdef SPRITE_READER_HFLIP_EN
    .hflip      (hflip),
`endif
    .draw_x     (draw_x),
    .mem        (mem_if),
    .pixel_rgb  (pixel_rgb),
    .pixel_valid(pixel_valid),
    .fetch_busy (fetch_busy),
    .overrun    (overrun)
  );

  // RAM: registered address, unregistered data
  logic [15:0] ram [2048];
  logic [10:0] addr_reg;
  always @(posedge clk) if (mem_if.mem_clken) addr_reg <= mem_if.mem_address;
  assign mem_if.mem_readdata = ram[addr_reg];

  int          tests = 0;
  int          fails = 0;
  int          cs_cycles = 0;
  int          busy_cycles = 0;
  logic [10:0] exp_addr_q [$];
  logic [16:0] exp_px_q [$];
  logic        px_chk = 1'b0;
  logic        px_chk_d = 1'b0;

  always @(posedge clk) px_chk_d <= px_chk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [10:0] ea;
    logic [16:0] ep;
    forever begin
      @(negedge clk);
      if (fetch_busy) busy_cycles++;
      if (mem_if.mem_chipselect) begin
        cs_cycles++;
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          check("mem_address", int'(mem_if.mem_address), int'(ea));
        end
      end
      if (px_chk_d) begin
        if (exp_px_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL px_underflow: pixel sample with no expected entry");
        end else begin
          ep = exp_px_q.pop_front();
          check("pixel_valid", int'(pixel_valid), int'(ep[16]));
          check("pixel_rgb", int'(pixel_rgb), int'(ep[15:0]));
        end
      end
    end
  endtask

  task automatic pulse(input logic [9:0] ny);
    @(posedge clk); #1;
    line_start = 1'b1;
    next_y     = ny;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic draw(input logic [9:0] x, input logic v, input logic [15:0] rgb);
    @(posedge clk); #1;
    draw_x = x;
    px_chk = 1'b1;
    exp_px_q.push_back({v, rgb});
    @(posedge clk); #1;
    px_chk = 1'b0;
  endtask

  task automatic push_row(input logic [10:0] base, input int n);
    for (int c = 0; c < n; c++) exp_addr_q.push_back(base + 11'(c));
  endtask

  int c0, b0;

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 16'(i);
    ram[11'h4C3] = 16'hF81F;
    reset = 1'b1; enable = 1'b0; line_start = 1'b0; frame_sel = 1'b0;
    next_y = '0; sprite_x = '0; sprite_y = '0; draw_x = '0;
`ifdef SPRITE_READER_HFLIP_EN
    hflip = 1'b0;
`endif
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_rgb", int'(pixel_rgb), 0);
    check("rst_pixel_valid", int'(pixel_valid), 0);
    check("rst_fetch_busy", int'(fetch_busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_chipselect", int'(mem_if.mem_chipselect), 0);
    reset = 1'b0;

    // Row 5 of frame 1: 0x4A0..0x4BF
    enable = 1'b1; sprite_y = 10'd100; frame_sel = 1'b1; sprite_x = 10'd200;
    c0 = cs_cycles; b0 = busy_cycles;
    push_row(11'h4A0, 32);
    pulse(10'd105);
    repeat (40) @(posedge clk);
    check("busy_len", busy_cycles - b0, 33);
    check("cs_len", cs_cycles - c0, 33);
    draw(10'd200, 1'b0, 16'h0000);

    // Row 5 becomes front while row 6 is fetched
    push_row(11'h4C0, 32);
    pulse(10'd106);
    draw(10'd200, 1'b1, 16'h04A0);
    draw(10'd231, 1'b1, 16'h04BF);
    draw(10'd232, 1'b0, 16'h0000);
    draw(10'd199, 1'b0, 16'h0000);
    draw(10'd215, 1'b1, 16'h04AF);
    repeat (40) @(posedge clk);

    // Out-of-range rows; row 6 (with colour key at col 3) becomes front
    c0 = cs_cycles;
    pulse(10'd99);
    draw(10'd202, 1'b1, 16'h04C2);
    draw(10'd203, 1'b0, 16'hF81F);
    draw(10'd204, 1'b1, 16'h04C4);
    pulse(10'd132);
    draw(10'd210, 1'b0, 16'h0000);
    sprite_y = 10'd1000;
    pulse(10'd5);
    draw(10'd210, 1'b0, 16'h0000);
    repeat (5) @(posedge clk);
    check("no_fetch_cs", cs_cycles - c0, 0);
    #1;
    check("no_fetch_busy", int'(fetch_busy), 0);

    // Overrun: interrupt row 7 after 10 issued words, restart on row 8
    sprite_y = 10'd100;
    check("overrun_before", int'(overrun), 0);
    push_row(11'h4E0, 10);
    push_row(11'h500, 32);
    pulse(10'd107);
    repeat (8) @(posedge clk);
    pulse(10'd108);
    check("overrun_set", int'(overrun), 1);
    draw(10'd200, 1'b0, 16'h0000);
    repeat (40) @(posedge clk);
    #1;
    check("overrun_sticky", int'(overrun), 1);
    pulse(10'd99);
    draw(10'd200, 1'b1, 16'h0500);
    draw(10'd231, 1'b1, 16'h051F);

    // Reset clears overrun and outputs; front is invalid afterwards
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_overrun", int'(overrun), 0);
    check("rst2_pixel_valid", int'(pixel_valid), 0);
    check("rst2_pixel_rgb", int'(pixel_rgb), 0);
    reset = 1'b0;
    draw(10'd200, 1'b0, 16'h0000);

`ifdef SPRITE_READER_HFLIP_EN
    // Mirrored row 5: addresses descend, stored ascending
    for (int c = 0; c < 32; c++) exp_addr_q.push_back(11'h4BF - 11'(c));
    hflip = 1'b1;
    pulse(10'd105);
    repeat (40) @(posedge clk);
    hflip = 1'b0;
    pulse(10'd99);
    draw(10'd200, 1'b1, 16'h04BF);
    draw(10'd231, 1'b1, 16'h04A0);
`endif

    repeat (3) @(posedge clk);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("px_q_empty", exp_px_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_sprite_line_reader.md
Name: vga_sprite_line_reader

Overview:
- Read-side client of the dual-port sprite RAM. Drives the 16-bit VGA-side port (11-bit word address, RGB565 word per pixel).
- During each scanline, prefetches the sprite row for the next line into a ping-pong line buffer.
- Emits a registered per-pixel colour and valid flag for the VGA colour mapper.
- Sprite layout: 32x32 pixels, 2 frames. Word address = {frame, row[4:0], col[4:0]}.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two; col index width = log2).
- SPR_H, 32, sprite height in lines.
- TRANSPARENT, 16'hF81F, RGB565 colour key; matching pixels are not drawn.
- ADDR_W, 11, sprite RAM word-address width.

Ports:
- clk  in  1  system clock; same clock as the RAM read port.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sprite visible; sampled at line_start.
- line_start  in  1  one-cycle pulse at start of each scanline.
- next_y  in  10  line to prefetch; valid with line_start.
- sprite_x  in  10  sprite left edge; sampled at line_start.
- sprite_y  in  10  sprite top edge; sampled at line_start.
- frame_sel  in  1  animation frame; sampled at line_start.
- draw_x  in  10  current displayed pixel column.
- mem_address  out  11  RAM port-2 word address.
- mem_chipselect  out  1  RAM port-2 chip select.
- mem_clken  out  1  RAM port-2 clock enable.
- mem_readdata  in  16  RAM port-2 read data; valid 1 cycle after address.
- pixel_rgb  out  16  RGB565 sprite pixel.
- pixel_valid  out  1  pixel_rgb is to be drawn.
- fetch_busy  out  1  prefetch in progress.
- overrun  out  1  sticky: line_start arrived while fetching.

Behaviour:
- Reset: all outputs 0, FSM IDLE, both buffer-valid flags 0, overrun 0, bank select 0.
- Write port 2 is never driven; mem_clken = mem_chipselect = fetch_busy.
- RAM read latency: address registered on clk, unregistered output; data for address issued in cycle k is captured in cycle k+1.
- Each bank holds SPR_W x 16-bit words, plus a valid bit and the latched sprite_x.

line_start handling (same cycle):
- Swap banks: the back bank (with its valid bit and x) becomes front.
- Latch sprite_x/sprite_y/frame_sel for the new back bank.
- row = {1'b0,next_y} - {1'b0,sprite_y}, computed in 11 bits.
- If enable and 0 <= row < SPR_H: clear back valid, enter FETCH with col=0.
- Otherwise: clear back valid, go to IDLE.

FSM:
- IDLE: mem signals low; wait for line_start.
- FETCH: issue address {frame, row[4:0], col}, col 0..SPR_W-1, one per cycle. After col SPR_W-1 is issued, go to DRAIN.
- DRAIN: one cycle; capture the last word, set back valid=1, go to IDLE.
- Write pipeline: the word for col k is written to back[k] in the cycle after it is issued.
- Fill time: SPR_W+1 cycles after line_start (33 by default).
- line_start during FETCH/DRAIN:
  - set overrun (sticky until reset);
  - the partially filled bank is swapped in with valid=0;
  - the new line fetch restarts from col=0.

Pixel output, registered with 1-cycle latency from draw_x:
- dx = {1'b0,draw_x} - {1'b0,front_x} in 11 bits, so there is no wrap at the screen edge.
- pixel_rgb <= front[dx[4:0]] if front valid and 0 <= dx < SPR_W; else 0.
- pixel_valid <= same condition AND word != TRANSPARENT.
- A sprite extending past column 639 is simply clipped. sprite_x > 639 means nothing is drawn.

Optional Feature:
- Macro SPRITE_READER_HFLIP_EN.
- When defined: extra input hflip (1 bit), sampled at line_start with the other sprite inputs. When 1, the fetch issues col index (SPR_W-1-col) but writes to back[col], so the row is stored mirrored. Latency and cycle count are unchanged.
- When undefined: no hflip port; column order is always ascending.

Test Plan:
- RAM preloaded with word = address. enable=1, sprite_y=100, frame=1, line_start with next_y=105 → addresses 0x4A0..0x4BF on consecutive cycles; fetch_busy high for 33 cycles; back valid set.
- Next line_start, then sweep draw_x with sprite_x=200:
  - draw_x=200 → next cycle pixel_rgb=0x04A0, valid=1;
  - draw_x=231 → 0x04BF;
  - draw_x=232 or 199 → valid=0, rgb=0.
- Word at col 3 = 16'hF81F → pixel_valid=0 at draw_x=203. Neighbouring columns 202 and 204 stay valid=1.
- Out-of-range rows:
  - next_y=99 or 132 with sprite_y=100 → no fetch, mem_chipselect stays 0, no pixels drawn on that line;
  - sprite_y=1000, next_y=5 → no fetch (11-bit arithmetic, no false match).
- line_start 10 cycles into a fetch → overrun=1 and remains 1; the swapped-in bank draws nothing; the new fetch starts at col 0. Reset clears overrun and all outputs.
- With SPRITE_READER_HFLIP_EN and hflip=1 on the row-5 scenario → issued addresses 0x4BF down to 0x4A0; draw_x=200 yields 0x04BF.
